// File: rtl/pulse_rle_encoder.sv
// Synchronises and glitch-filters a raw pulse input, then emits run-length tokens on a valid/ready stream.
// Optional macro RLE_FILTER_EN enables the FILTER_LEN glitch filter; when undefined, level follows the synchroniser directly.
module pulse_rle_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   in,
    output logic                   tok_valid,
    input  logic                   tok_ready,
    output logic                   tok_level,
    output logic [COUNT_WIDTH-1:0] tok_len,
    output logic                   level,
    output logic                   overflow
);

    typedef struct packed {
        logic                   lvl;
        logic [COUNT_WIDTH-1:0] len;
    } tok_t;

    localparam logic [COUNT_WIDTH-1:0] RUN_MAX = '1;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
        $error("pulse_rle_encoder: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   nxt_level;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], in};
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef RLE_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FW-1:0] flt_cnt;
    logic          flt_hit;

    // Toggle only after FILTER_LEN consecutive disagreeing samples, so both edges see the same delay.
    assign flt_hit   = (s != level) && (flt_cnt == FW'(FILTER_LEN - 1));
    assign nxt_level = flt_hit ? ~level : level;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            flt_cnt <= '0;
        end else begin
            level <= nxt_level;
            if (s == level || flt_hit) flt_cnt <= '0;
            else                       flt_cnt <= flt_cnt + 1'b1;
        end
    end
`else
    assign level     = s;
    assign nxt_level = sync[SYNC_STAGES-2];
`endif

    logic [COUNT_WIDTH-1:0] run_cnt;
    logic [COUNT_WIDTH-1:0] run_nxt;
    logic                   toggle;
    logic                   gen;
    tok_t                   gen_tok;
    tok_t                   out_q;

    // run_nxt is the number of cycles the current level has been held, including this one.
    assign run_nxt = run_cnt + 1'b1;
    assign toggle  = (nxt_level != level);
    assign gen     = toggle || (run_nxt == RUN_MAX);
    assign gen_tok = '{lvl: level, len: run_nxt};

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)      run_cnt <= '0;
        else if (gen) run_cnt <= '0;
        else          run_cnt <= run_nxt;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tok_valid <= 1'b0;
            out_q     <= '0;
            overflow  <= 1'b0;
        end else if (gen) begin
            if (!tok_valid || tok_ready) begin
                out_q     <= gen_tok;
                tok_valid <= 1'b1;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (tok_valid && tok_ready) begin
            tok_valid <= 1'b0;
        end
    end

    assign tok_level = out_q.lvl;
    assign tok_len   = out_q.len;

endmodule

// File: tb/tb_pulse_rle_encoder.sv
// Randomised scoreboard bench for pulse_rle_encoder; reference model tracks windows of samples and run lengths.
module tb_pulse_rle_encoder;

    localparam int SYNC = 2;
    localparam int FL   = 4;
    localparam int CW   = 8;
    localparam int MAX  = (1 << CW) - 1;
`ifdef RLE_FILTER_EN
    localparam int EXP_LAT = SYNC + FL;
`else
    localparam int EXP_LAT = SYNC;
`endif

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          in = 1'b0;
    logic          tok_ready = 1'b1;
    logic          tok_valid, tok_level, level, overflow;
    logic [CW-1:0] tok_len;

    pulse_rle_encoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .COUNT_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst(rst), .in(in),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_level(tok_level), .tok_len(tok_len),
        .level(level), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit lvl;
        int len;
    } tok_t;

    tok_t exp_q[$];
    bit   shq[$];
    bit   win[$];
    bit   mlevel, mvalid, movf;
    int   held;

    task automatic model_reset();
        shq.delete();
        win.delete();
        for (int i = 0; i < SYNC; i++) shq.push_back(1'b0);
        for (int i = 0; i < FL; i++)   win.push_back(1'b0);
        mlevel = 0; mvalid = 0; movf = 0; held = 0;
        exp_q.delete();
    endtask

    // One clock of the reference: delayed sample, windowed level decision, run bookkeeping, one-slot output.
    task automatic model_step(input bit vin, input bit vr);
        bit   s_pre, nl, all_diff, gen;
        tok_t t;
        s_pre = shq[SYNC-1];
        shq.push_front(vin);
        void'(shq.pop_back());
`ifdef RLE_FILTER_EN
        win.push_front(s_pre);
        void'(win.pop_back());
        all_diff = 1;
        foreach (win[i]) if (win[i] == mlevel) all_diff = 0;
        nl = all_diff ? ~mlevel : mlevel;
`else
        all_diff = s_pre;
        nl = shq[SYNC-1];
`endif
        held++;
        gen = (nl != mlevel) || (held == MAX);
        if (gen) begin
            t.lvl = mlevel;
            t.len = held;
            held  = 0;
            if (!mvalid || vr) begin
                exp_q.push_back(t);
                mvalid = 1;
            end else begin
                movf = 1;
            end
        end else if (mvalid && vr) begin
            mvalid = 0;
        end
        mlevel = nl;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            if (rst) model_reset();
            else     model_step(in, tok_ready);
        end
    end

    int sat_seen = 0;

    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                chk("level", level, mlevel);
                chk("overflow", overflow, movf);
                chk("tok_valid", tok_valid, mvalid);
                if (tok_valid) begin
                    chk("sb_depth", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        chk("tok_level", tok_level, exp_q[0].lvl);
                        chk("tok_len", tok_len, exp_q[0].len);
                        if (tok_ready) begin
                            if (int'(tok_len) == MAX) sat_seen++;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    bit rnd_rdy  = 0;
    bit rdy_hold = 1;

    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            in = v;
            tok_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
        end
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_tok_valid", tok_valid, 0);
        chk("rst_tok_level", tok_level, 0);
        chk("rst_tok_len", tok_len, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;

        // Periodic 100 low / 10 high, with rise latency measured each period.
        for (int p = 0; p < 5; p++) begin
            drive(0, 100);
            drive(1, 1);
            lat = 0;
            while (!level && lat < 50) begin
                @(posedge clk_in);
                #1;
                lat++;
            end
            chk("rise_latency", lat, EXP_LAT);
            if (lat < 9) drive(1, 9 - lat);
        end
        drive(0, 100);
        chk("periodic_overflow", overflow, 0);

        // Short glitch inside a long low run.
        drive(0, 50); drive(1, 3); drive(0, 60); drive(1, 20); drive(0, 20);

        // Saturation of a long high run.
        sat_seen = 0;
        drive(1, 600); drive(0, 40);
        chk("sat_tokens", int'(sat_seen >= 2), 1);
        chk("sat_overflow", overflow, 0);

        // Backpressure: first token held, later ones dropped.
        rdy_hold = 0;
        drive(0, 20); drive(1, 20); drive(0, 20); drive(1, 20); drive(0, 30);
        chk("bp_valid_held", tok_valid, 1);
        chk("bp_overflow", overflow, 1);
        rdy_hold = 1;
        drive(0, 1);
        rdy_hold = 0;
        drive(0, 1);
        chk("bp_valid_drop", tok_valid, 0);
        rdy_hold = 1;

        // Async reset 50 cycles into a high run.
        drive(0, 20);
        drive(1, EXP_LAT + 50);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", tok_valid, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_len", tok_len, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        in  = 1'b0;
        drive(0, 30); drive(1, 20); drive(0, 20);

        // Random pulse widths with random consumer readiness.
        rnd_rdy = 1;
        for (int k = 0; k < 150; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        rnd_rdy  = 0;
        rdy_hold = 1;
        drive(in, 60);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d checks expected completion", total);
        $fatal(1);
    end

endmodule
